// File: rtl/cmp_arbiter_if.sv
// rtl/cmp_arbiter_if.sv - requester and shared-comparator signal bundle for cmp_arbiter
interface cmp_arbiter_if;
  logic       req0;
  logic [1:0] a0;
  logic [1:0] b0;
  logic       req1;
  logic [1:0] a1;
  logic [1:0] b1;
  logic       gnt0;
  logic       gnt1;
  logic       done0;
  logic       done1;
  logic       res_lt;
  logic       res_gt;
  logic       res_eq;
  logic [1:0] cmp_a;
  logic [1:0] cmp_b;
  logic       cmp_lt;
  logic       cmp_gt;
  logic       cmp_eq;

  modport master (
    output req0, a0, b0, req1, a1, b1,
    input  gnt0, gnt1, done0, done1, res_lt, res_gt, res_eq
  );

  modport slave (
    input  req0, a0, b0, req1, a1, b1, cmp_lt, cmp_gt, cmp_eq,
    output gnt0, gnt1, done0, done1, res_lt, res_gt, res_eq, cmp_a, cmp_b
  );

  modport comparator (
    input  cmp_a, cmp_b,
    output cmp_lt, cmp_gt, cmp_eq
  );
endinterface

// File: rtl/cmp_arbiter.sv
// rtl/cmp_arbiter.sv - round-robin arbiter and sequencer for a shared 2-bit magnitude comparator
module cmp_arbiter #(
  parameter bit RR_INIT = 1'b0,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  cmp_arbiter_if.slave     bus,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] lookups
);
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOOKUP = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [1:0] state;
  logic       ptr;
  logic       win;
  logic       any_req;
  logic       pick;
  logic       one_hot;

  assign any_req = bus.req0 | bus.req1;
  // Under contention the pointer decides; otherwise the lone requester wins.
  assign pick    = (bus.req0 & bus.req1) ? ptr : bus.req1;
  assign one_hot = (bus.cmp_lt ^ bus.cmp_gt ^ bus.cmp_eq)
                 & ~(bus.cmp_lt & bus.cmp_gt & bus.cmp_eq);
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      ptr        <= RR_INIT;
      win        <= 1'b0;
      bus.gnt0   <= 1'b0;
      bus.gnt1   <= 1'b0;
      bus.done0  <= 1'b0;
      bus.done1  <= 1'b0;
      bus.cmp_a  <= 2'd0;
      bus.cmp_b  <= 2'd0;
      bus.res_lt <= 1'b0;
      bus.res_gt <= 1'b0;
      bus.res_eq <= 1'b0;
      err        <= 1'b0;
      lookups    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            state     <= ST_LOOKUP;
            win       <= pick;
            ptr       <= ~pick;
            bus.gnt0  <= ~pick;
            bus.gnt1  <= pick;
            bus.cmp_a <= pick ? bus.a1 : bus.a0;
            bus.cmp_b <= pick ? bus.b1 : bus.b0;
          end
        end
        ST_LOOKUP: begin
          state      <= ST_DONE;
          bus.res_lt <= bus.cmp_lt;
          bus.res_gt <= bus.cmp_gt;
          bus.res_eq <= bus.cmp_eq;
          if (!one_hot) begin
            err <= 1'b1;
          end
          bus.done0  <= ~win;
          bus.done1  <= win;
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          bus.done0 <= 1'b0;
          bus.done1 <= 1'b0;
          bus.gnt0  <= 1'b0;
          bus.gnt1  <= 1'b0;
          lookups   <= lookups + CNT_W'(1);
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule
